// File: rtl/pong_game_sequencer_if.sv
// Game-flow bus between the sequencer, the ball datapath and the score/screen logic.
interface pong_game_sequencer_if;
  logic       start;
  logic       frame_tick;
  logic       miss_left;
  logic       miss_right;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] state;

  // Driver side: buttons, frame timing and miss reports; observes game status.
  modport master (
    output start, frame_tick, miss_left, miss_right,
    input  ball_run, ball_center, serve_dir, p1_score, p2_score, winner, state
  );

  // Sequencer side.
  modport slave (
    input  start, frame_tick, miss_left, miss_right,
    output ball_run, ball_center, serve_dir, p1_score, p2_score, winner, state
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: sequences rallies, keeps both scores and the winner,
// and gates the ball datapath. Every output comes straight from a register.
module pong_game_sequencer #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  pong_game_sequencer_if.slave game_io
);

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);
  localparam logic [7:0] PointFrames = 8'(POINT_FRAMES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d;
  logic [3:0] p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       ball_center_q, ball_center_d;
  logic       ball_run_q, ball_run_d;
  logic       start_q;

  logic       start_rise;
  logic [3:0] p1_inc, p2_inc;
  logic [7:0] cnt_inc;

  assign start_rise = game_io.start & ~start_q;
  assign p1_inc     = p1_q + 4'd1;
  assign p2_inc     = p2_q + 4'd1;
  assign cnt_inc    = cnt_q + 8'd1;

  // Next-state logic: rally sequencing, scoring and frame counting.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    winner_d      = winner_q;
    serve_dir_d   = serve_dir_q;
    ball_center_d = 1'b0;

    case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          state_d       = StServe;
          p1_d          = 4'd0;
          p2_d          = 4'd0;
          winner_d      = 2'd0;
          serve_dir_d   = 1'b0;
          cnt_d         = 8'd0;
          ball_center_d = 1'b1;
        end
      end
      StServe: begin
        if (game_io.frame_tick) begin
          if (cnt_inc == ServeFrames) begin
            state_d = StPlay;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StPlay: begin
        if (game_io.miss_left && game_io.miss_right) begin
          // Simultaneous misses: replay the serve without scoring.
          state_d       = StServe;
          cnt_d         = 8'd0;
          ball_center_d = 1'b1;
        end else if (game_io.miss_left) begin
          p2_d        = p2_inc;
          serve_dir_d = 1'b1;
          cnt_d       = 8'd0;
          if (p2_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 2'd2;
          end else begin
            state_d = StPoint;
          end
        end else if (game_io.miss_right) begin
          p1_d        = p1_inc;
          serve_dir_d = 1'b0;
          cnt_d       = 8'd0;
          if (p1_inc == WinScore) begin
            state_d  = StOver;
            winner_d = 2'd1;
          end else begin
            state_d = StPoint;
          end
        end
      end
      StPoint: begin
        if (game_io.frame_tick) begin
          if (cnt_inc == PointFrames) begin
            state_d       = StServe;
            cnt_d         = 8'd0;
            ball_center_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    // Registered so ball_run follows the state that is being entered.
    ball_run_d = (state_d == StPlay);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= 8'd0;
      p1_q          <= 4'd0;
      p2_q          <= 4'd0;
      winner_q      <= 2'd0;
      serve_dir_q   <= 1'b0;
      ball_center_q <= 1'b0;
      ball_run_q    <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      serve_dir_q   <= serve_dir_d;
      ball_center_q <= ball_center_d;
      ball_run_q    <= ball_run_d;
      start_q       <= game_io.start;
    end
  end

  assign game_io.state       = state_q;
  assign game_io.p1_score    = p1_q;
  assign game_io.p2_score    = p2_q;
  assign game_io.winner      = winner_q;
  assign game_io.serve_dir   = serve_dir_q;
  assign game_io.ball_center = ball_center_q;
  assign game_io.ball_run    = ball_run_q;

endmodule

// File: doc/pong_game_sequencer.md
Name: pong_game_sequencer

Overview:
Central game-flow controller for the FPGA ping-pong design. It sequences each rally (idle, serve delay, live play, post-point pause, game over), owns both players' score counters and the winner code, and gates the ball datapath with run/centre controls. It sits between the ball-motion logic, which reports misses, and the score decoder and screen renderer, which consume scores, winner and state.

Parameters:
WIN_SCORE, 7, points needed to win; range 1..15.
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; range 1..255.
POINT_FRAMES, 90, frame ticks spent in POINT after a score; range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  new-game button, level; rising edge detected internally
frame_tick  in  1  one-cycle pulse per video frame
miss_left  in  1  one-cycle pulse: ball passed paddle 1 (point to P2)
miss_right  in  1  one-cycle pulse: ball passed paddle 2 (point to P1)
ball_run  out  1  ball motion enable; high only in PLAY
ball_center  out  1  one-cycle pulse: recentre ball
serve_dir  out  1  0 = serve toward P2 (right), 1 = serve toward P1 (left)
p1_score  out  4  player 1 score
p2_score  out  4  player 2 score
winner  out  2  0 none, 1 P1, 2 P2
state  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER

Behaviour:
- Reset is synchronous and active-high: state IDLE, scores 0, winner 0, ball_run 0, ball_center 0, serve_dir 0, frame counter 0, start_q 0. Reset asserted mid-game restores all of these at the next edge.
- All outputs are registered. An input event sampled at edge N is reflected on the outputs after edge N.
- start_rise = start & ~start_q. start_q is registered every cycle.
- IDLE: on start_rise -> SERVE. Clear scores and winner, set serve_dir 0, counter 0, pulse ball_center.
- SERVE: ball_run 0. Each frame_tick increments the counter. The tick that brings the count to SERVE_FRAMES -> PLAY, and the counter is cleared.
- PLAY: ball_run 1.
  - miss_left alone: p2_score+1, serve_dir 1.
  - miss_right alone: p1_score+1, serve_dir 0.
  - If the incremented score equals WIN_SCORE -> OVER, with winner 2 (P2) or 1 (P1). Otherwise -> POINT.
  - miss_left and miss_right in the same cycle: a let. No score change, serve_dir unchanged -> SERVE, pulse ball_center, counter 0.
- POINT: ball_run 0. The POINT_FRAMES-th frame_tick -> SERVE, pulse ball_center, counter 0.
- OVER: ball_run 0; scores and winner hold. start_rise -> SERVE with the same actions as from IDLE.
- Misses are ignored outside PLAY. frame_tick is ignored in IDLE and OVER. start_rise is ignored in SERVE, PLAY and POINT.
- ball_center is high for exactly one cycle per entry into SERVE and is otherwise 0.
- Scores never exceed WIN_SCORE, because the game ends on reaching it. The counter is 8 bits and never wraps.
- frame_tick coinciding with a state-entry cycle is not counted. Counting starts the cycle after entry.
- Invalid state encodings (5..7) -> IDLE on the next edge.

Test Plan:
- Reset, then start held high 10 cycles -> exactly one ball_center pulse; state 1; after 60 frame_ticks state 2 and ball_run 1; start held high does not retrigger.
- In PLAY, miss_right pulse -> next cycle p1_score 1, serve_dir 0, state 3, ball_run 0; after 90 ticks state 1 with ball_center pulse.
- Seven miss_left points, each followed by the full pause/serve -> p2_score 7, winner 2, state 4; further misses and ticks leave everything unchanged.
- miss_left and miss_right in the same PLAY cycle -> scores unchanged, state 1, ball_center pulse, serve_dir unchanged.
- Misses injected during SERVE and POINT, plus a start edge during PLAY -> no score or state effect.
- reset asserted in POINT with scores 3:5 -> next cycle all outputs at reset values; in OVER, a start edge -> scores 0, winner 0, state 1.
